alu_muldiv: RTL and testbench

Parametrised successor to the single-cycle MIPS ALU. It keeps the combinational R-type operations and adds a sequential multiply/divide unit with architectural HI/LO registers, a start/busy/done handshake and MFHI/MFLO readback. It sits in the EX stage, driven by the existing ALU_Control decode, which is extended with the new ALU_Ctl codes below.

---
 rtl/alu_muldiv.sv | 149 ++++++++++++++
 tb/tb_alu_muldiv.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational R-type ops plus a shift-add multiply / restoring divide into HI/LO.
// Mul/div takes WIDTH+2 cycles per op; start is ignored while busy. There is no stall path.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Ctl,
   input  logic             start,
   output logic [WIDTH-1:0] Output,
   output logic             Zero_Flag,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             q_neg;
   logic             r_neg;
   logic             div_zero;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;

   logic             is_seq;
   logic             launch;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_fix;

   assign is_seq = (ALU_Ctl[3:2] == 2'b10);
   assign launch = (state == IDLE) && start && is_seq;
   assign a_neg  = ALU_Ctl[0] & A[WIDTH-1];
   assign b_neg  = ALU_Ctl[0] & B[WIDTH-1];
   assign a_mag  = a_neg ? -A : A;
   assign b_mag  = b_neg ? -B : B;

   // One iteration step for each algorithm; acc:q acts as a shared double-width shift register.
   assign add_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
   assign div_shift = {acc, q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, m};

   assign prod     = {acc, q};
   assign prod_fix = q_neg ? -prod : prod;
   // Divide-by-zero leaves |A| in acc, so the dividend-sign fix-up restores A itself.
   assign rem_fix  = r_neg ? -acc : acc;
   assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (q_neg ? -q : q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         is_div   <= 1'b0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         div_zero <= 1'b0;
         acc      <= '0;
         q        <= '0;
         m        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  is_div   <= ALU_Ctl[1];
                  q_neg    <= a_neg ^ b_neg;
                  r_neg    <= a_neg;
                  div_zero <= ALU_Ctl[1] && (B == '0);
                  acc      <= '0;
                  q        <= ALU_Ctl[1] ? a_mag : b_mag;
                  m        <= ALU_Ctl[1] ? b_mag : a_mag;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= FIX;
               if (is_div) begin
                  if (!div_diff[WIDTH]) begin
                     acc <= div_diff[WIDTH-1:0];
                     q   <= {q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= div_shift[WIDTH-1:0];
                     q   <= {q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= add_sum[WIDTH:1];
                  q   <= {add_sum[0], q[WIDTH-1:1]};
               end
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (is_div) begin
                  HI <= rem_fix;
                  LO <= quo_fix;
               end else begin
                  HI <= prod_fix[2*WIDTH-1:WIDTH];
                  LO <= prod_fix[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      Output = '0;
      case (ALU_Ctl)
         4'b0000: Output = A & B;
         4'b0001: Output = A | B;
         4'b0010: Output = A + B;
         4'b0110: Output = A - B;
         4'b0111: Output = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'b1100: Output = ~(A | B);
         4'b1101: Output = HI;
         4'b1110: Output = LO;
         default: Output = '0;
      endcase
   end

   assign Zero_Flag = (Output == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32 with hand-computed results.
module tb_alu_muldiv;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [3:0]   ALU_Ctl;
   logic         start;
   logic [W-1:0] Output;
   logic         Zero_Flag;
   logic         busy;
   logic         done;
   logic [W-1:0] HI;
   logic [W-1:0] LO;

   int           n_vec;
   int           n_err;
   logic [W-1:0] prev_hi;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .ALU_Ctl   (ALU_Ctl),
      .start     (start),
      .Output    (Output),
      .Zero_Flag (Zero_Flag),
      .busy      (busy),
      .done      (done),
      .HI        (HI),
      .LO        (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic comb(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input logic exp_z);
      A = a; B = b; ALU_Ctl = ctl;
      #1;
      chk(tag, Output, exp);
      chk({tag, ":zero"}, {31'd0, Zero_Flag}, {31'd0, exp_z});
   endtask

   // Launch at edge 0, poke start at edge 5, watch MFHI while busy, expect done at edge 33.
   task automatic run_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int   cyc;
      logic early;
      A = a; B = b; ALU_Ctl = ctl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ":busy_e0"}, {31'd0, busy}, 32'd1);
      chk({tag, ":done_e0"}, {31'd0, done}, 32'd0);
      A = 32'hDEAD_BEEF; B = 32'h0000_0001; ALU_Ctl = 4'b1101;
      #1;
      chk({tag, ":mfhi_busy"}, Output, prev_hi);
      cyc = 0; early = 1'b0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 4) begin start = 1'b1; ALU_Ctl = 4'b1000; end
         if (cyc == 5) begin start = 1'b0; ALU_Ctl = 4'b1101; end
         if (done) break;
         if (!busy) early = 1'b1;
      end
      chk({tag, ":latency"}, cyc, 32'd33);
      chk({tag, ":busy_run"}, {31'd0, early}, 32'd0);
      chk({tag, ":busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, ":hi"}, HI, exp_hi);
      chk({tag, ":lo"}, LO, exp_lo);
      prev_hi = exp_hi;
   endtask

   initial begin
      int seen;
      n_vec = 0; n_err = 0; prev_hi = '0;
      reset = 1'b1; A = '0; B = '0; ALU_Ctl = 4'b0000; start = 1'b0;
      #1;
      chk("rst:hi", HI, 32'd0);
      chk("rst:lo", LO, 32'd0);
      chk("rst:busy", {31'd0, busy}, 32'd0);
      chk("rst:done", {31'd0, done}, 32'd0);
      chk("rst:out", Output, 32'd0);
      chk("rst:zero", {31'd0, Zero_Flag}, 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      comb("add",  4'b0010, 32'h13989207, 32'h13989208, 32'h2731240F, 1'b0);
      comb("sub",  4'b0110, 32'h13989207, 32'h13989208, 32'hFFFFFFFF, 1'b0);
      comb("slt",  4'b0111, 32'h13989207, 32'h13989208, 32'h00000001, 1'b0);
      comb("slt_neg", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      comb("and",  4'b0000, 32'h13989207, 32'h13989208, 32'h13989200, 1'b0);
      comb("or",   4'b0001, 32'h13989207, 32'h13989208, 32'h1398920F, 1'b0);
      comb("nor",  4'b1100, 32'h13989207, 32'h13989208, 32'hEC676DF0, 1'b0);
      comb("sub_eq", 4'b0110, 32'h13989207, 32'h13989207, 32'h00000000, 1'b1);
      comb("undef", 4'b0011, 32'h13989207, 32'h13989208, 32'h00000000, 1'b1);
      comb("seqsel", 4'b1000, 32'h13989207, 32'h13989208, 32'h00000000, 1'b1);
      @(posedge clk); #1;

      run_op("multu", 4'b1000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
      ALU_Ctl = 4'b1110; #1;
      chk("mflo", Output, 32'hFFFFFFFE);
      ALU_Ctl = 4'b1101; #1;
      chk("mfhi", Output, 32'h00000001);
      run_op("mult",   4'b1001, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div",    4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_pn", 4'b1011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("div_ovf", 4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("divu",   4'b1010, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
      run_op("div_z",  4'b1011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run_op("divu_z", 4'b1010, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);

      A = 32'd100; B = 32'd7; ALU_Ctl = 4'b1010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort:busy", {31'd0, busy}, 32'd0);
      chk("abort:hi", HI, 32'd0);
      chk("abort:lo", LO, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("abort:no_done", seen, 32'd0);
      prev_hi = '0;

      run_op("post_rst", 4'b1000, 32'd6, 32'd7, 32'd0, 32'd42);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
